// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared constants, state encoding and burst-length rule for the MAC scatter path
package mac_pkg;

  localparam int LANES = 16;
  localparam int SEL_W = 4;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A requested count of zero stands for a full sweep of all lanes.
  function automatic logic [CNT_W-1:0] burst_len(input logic [CNT_W-1:0] c);
    return (c == '0) ? CNT_W'(LANES) : c;
  endfunction

endpackage

// File: rtl/mac_lane_counter.sv
// rtl/mac_lane_counter.sv - loadable wrap-around lane index; load has priority over inc
module mac_lane_counter
  import mac_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [SEL_W-1:0] base,
  input  logic             inc,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] r_idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idx <= '0;
    end else if (load) begin
      r_idx <= base;
    end else if (inc) begin
      r_idx <= r_idx + SEL_W'(1);
    end
  end

  assign idx = r_idx;

endmodule

// File: rtl/mac_scatter_sequencer.sv
// rtl/mac_scatter_sequencer.sv - spreads a burst of MAC words over consecutive demux lanes
module mac_scatter_sequencer
  import mac_pkg::*;
#(
  parameter int nrOfBits = 16
)
(
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [SEL_W-1:0]    base,
  input  logic [CNT_W-1:0]    count,
  input  logic                abort,
  input  logic [nrOfBits-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [nrOfBits-1:0] demuxIn,
  output logic [SEL_W-1:0]    sel,
  output logic                enable,
  output logic                busy,
  output logic                done,
  output logic [LANES-1:0]    lane_written
);

  state_t           r_state;
  logic [CNT_W-1:0] r_remaining;
  logic [SEL_W-1:0] w_idx;
  logic             w_accept;
  logic             w_load;

  assign in_ready = (r_state == RUN) && !abort;
  assign w_accept = in_ready && in_valid;
  assign w_load   = (r_state == IDLE) && start;
  assign busy     = (r_state != IDLE);

  mac_lane_counter u_lane_counter (
    .clock (clock),
    .reset (reset),
    .load  (w_load),
    .base  (base),
    .inc   (w_accept),
    .idx   (w_idx)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_remaining  <= '0;
      demuxIn      <= '0;
      sel          <= '0;
      enable       <= 1'b0;
      done         <= 1'b0;
      lane_written <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          enable <= 1'b0;
          done   <= 1'b0;
          if (start) begin
            r_remaining  <= burst_len(count);
            lane_written <= '0;
            r_state      <= RUN;
          end
        end
        RUN: begin
          done <= 1'b0;
          if (abort) begin
            // Lanes already written stay marked so software can see how far it got.
            enable  <= 1'b0;
            r_state <= IDLE;
          end else if (w_accept) begin
            demuxIn             <= in_data;
            sel                 <= w_idx;
            enable              <= 1'b1;
            lane_written[w_idx] <= 1'b1;
            r_remaining         <= r_remaining - CNT_W'(1);
            if (r_remaining == CNT_W'(1)) begin
              done    <= 1'b1;
              r_state <= DONE;
            end
          end else begin
            enable <= 1'b0;
          end
        end
        DONE: begin
          enable  <= 1'b0;
          done    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          enable  <= 1'b0;
          done    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_scatter_sequencer.sv
// tb/tb_mac_scatter_sequencer.sv - directed table plus randomized bursts against a lane-list model
module tb_mac_scatter_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  base = '0;
  logic [4:0]  count = '0;
  logic        abort = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] demuxIn;
  logic [3:0]  sel;
  logic        enable;
  logic        busy;
  logic        done;
  logic [15:0] lane_written;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  mac_scatter_sequencer #(.nrOfBits(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .base         (base),
    .count        (count),
    .abort        (abort),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .demuxIn      (demuxIn),
    .sel          (sel),
    .enable       (enable),
    .busy         (busy),
    .done         (done),
    .lane_written (lane_written)
  );

  typedef struct {
    logic [3:0]  b;
    logic [4:0]  c;
    int          mode;        // 0 always valid, 1 alternate, 2 random
    int          abort_after; // 0 means no abort
    bit          mid_start;
    logic [15:0] exp_mask;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_burst(input logic [3:0] b, input logic [4:0] c, input int mode,
                           input int abort_after, input bit mid_start, input logic [15:0] exp_mask,
                           input bit rand_data);
    int n;
    int acc;
    int cyc;
    bit v;
    bit ab;
    bit finished;
    logic [15:0] words[16];
    n = (c == 0) ? 16 : int'(c);
    for (int k = 0; k < 16; k++) words[k] = rand_data ? 16'($urandom) : 16'(16'h0011 * (k + 1));
    acc = 0;
    finished = 0;
    start = 1'b1; base = b; count = c;
    tick();
    start = 1'b0;
    base = 4'($urandom); count = 5'($urandom);
    check("busy_after_start", busy, 1);
    check("lane_written_cleared", lane_written, 0);
    check("enable_after_start", enable, 0);
    for (cyc = 0; cyc < 200 && !finished; cyc++) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      ab = (abort_after != 0) && (acc == abort_after);
      abort = ab;
      in_valid = ab ? 1'b1 : v;
      in_data = ab ? 16'hDEAD : words[acc];
      if (mid_start && acc == 1) begin
        start = 1'b1; base = 4'd9; count = 5'd3;
      end
      #1;
      check("in_ready", in_ready, {31'b0, !ab});
      tick();
      start = 1'b0;
      check("enable", enable, {31'b0, v && !ab});
      if (v && !ab) begin
        check("sel", sel, 32'((int'(b) + acc) % 16));
        check("demuxIn", demuxIn, words[acc]);
        acc++;
      end
      if (ab) begin
        abort = 1'b0; in_valid = 1'b0;
        check("busy_after_abort", busy, 0);
        check("no_done_on_abort", done, 0);
        finished = 1;
      end else if (acc == n) begin
        in_valid = 1'b0;
        check("done_pulse", done, 1);
        check("busy_in_done", busy, 1);
        tick();
        check("done_cleared", done, 0);
        check("enable_cleared", enable, 0);
        check("busy_cleared", busy, 0);
        finished = 1;
      end else begin
        check("done_early", done, 0);
      end
    end
    check("burst_timeout", {31'b0, finished}, 1);
    check("lane_written", lane_written, exp_mask);
    check("in_ready_idle", in_ready, 0);
    abort = 1'b0; in_valid = 1'b0;
    tick();
  endtask

  vec_t vecs[5];

  initial begin
    logic [3:0]  rb;
    logic [4:0]  rc;
    int          rn;
    int          ra;
    logic [15:0] rmask;

    vecs[0] = '{4'd0,  5'd4, 0, 0, 1'b0, 16'h000F};
    vecs[1] = '{4'd14, 5'd4, 0, 0, 1'b0, 16'hC003};
    vecs[2] = '{4'd5,  5'd0, 0, 0, 1'b0, 16'hFFFF};
    vecs[3] = '{4'd2,  5'd8, 1, 3, 1'b0, 16'h001C};
    vecs[4] = '{4'd3,  5'd6, 0, 0, 1'b1, 16'h01F8};

    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_enable", enable, 0);
    check("rst_busy", busy, 0);
    check("rst_lane_written", lane_written, 0);
    tick();
    reset = 1'b0;
    tick();
    in_valid = 1'b1;
    #1;
    check("idle_in_ready", in_ready, 0);
    in_valid = 1'b0;
    tick();

    for (int i = 0; i < 5; i++)
      run_burst(vecs[i].b, vecs[i].c, vecs[i].mode, vecs[i].abort_after,
                vecs[i].mid_start, vecs[i].exp_mask, 1'b0);

    // Reset in the middle of a burst after three beats.
    start = 1'b1; base = 4'd0; count = 5'd8;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 16'(16'h0100 + k);
      tick();
    end
    check("pre_reset_enable", enable, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_enable", enable, 0);
    check("mid_rst_sel", sel, 0);
    check("mid_rst_demuxIn", demuxIn, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_lane_written", lane_written, 0);
    check("mid_rst_in_ready", in_ready, 0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post_rst_in_ready", in_ready, 0);
      check("post_rst_enable", enable, 0);
    end
    in_valid = 1'b0;

    for (int i = 0; i < 8; i++) begin
      rb = 4'($urandom_range(0, 15));
      rc = 5'($urandom_range(0, 16));
      rn = (rc == 0) ? 16 : int'(rc);
      ra = (rn > 1 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, rn - 1)) : 0;
      rmask = '0;
      for (int k = 0; k < ((ra != 0) ? ra : rn); k++) rmask[(int'(rb) + k) % 16] = 1'b1;
      run_burst(rb, rc, 2, ra, 1'b0, rmask, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_scatter_sequencer.md
# mac_scatter_sequencer

Upstream stage of the 16-way bus demultiplexer in the MAC datapath. It accepts a burst of MAC result words over a valid/ready handshake and drives the demultiplexer's data, select and enable inputs so that consecutive words land in consecutive lanes, starting at a programmable base lane. Each word produces exactly one single-cycle enable pulse. Lane index wraps modulo 16.

## Interface
Parameters:
- nrOfBits, 16, width of one data word (matches the demultiplexer's nrOfBits)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- start  in  1  begin a burst; sampled only in IDLE
- base  in  4  first lane of the burst; latched with start
- count  in  5  words in the burst; 1..16; value 0 is treated as 16; latched with start
- abort  in  1  terminate the current burst
- in_data  in  nrOfBits  result word
- in_valid  in  1  in_data is valid
- in_ready  out  1  sequencer accepts a word this cycle
- demuxIn  out  nrOfBits  word to the demultiplexer, registered
- sel  out  4  target lane, registered
- enable  out  1  one-cycle write strobe to the demultiplexer, registered
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse at normal burst completion
- lane_written  out  16  sticky mask of lanes written in the current or most recent burst

## Operation
- States: IDLE, RUN, DONE. Encoding comes from the package.
- IDLE:
  - in_ready=0.
  - On start: latch idx←base and remaining←(count==0 ? 16 : count), clear lane_written, go to RUN.
- RUN:
  - in_ready = ~abort.
  - A beat is accepted when in_valid & in_ready. On an accepted beat:
    - demuxIn←in_data, sel←idx, enable←1, lane_written[idx]←1.
    - idx←idx+1 modulo 16 (15 wraps to 0).
    - remaining←remaining−1.
  - If remaining was 1 on the accepted beat, go to DONE.
  - No beat that cycle: enable←0; demuxIn and sel hold their values.
- DONE: lasts one cycle. done=1, enable carries the final beat's strobe, then go to IDLE.
- abort in RUN: in_ready is forced to 0 that cycle and the block goes to IDLE at the next edge. No done pulse. lane_written keeps the lanes already written. abort in IDLE or DONE is ignored.
- start outside IDLE is ignored. base and count are not re-sampled mid-burst.
- A burst of 16 words from any base writes every lane exactly once.
- Reset mid-burst: immediate return to IDLE with all outputs at reset values. The partial burst is discarded.

## Timing
- Reset values: in_ready=0, demuxIn=0, sel=0, enable=0, busy=0, done=0, lane_written=0, state=IDLE, idx=0, remaining=0.
- start sampled at edge E → RUN, busy=1 and in_ready=1 from cycle E+1.
- Beat accepted at edge N → enable=1, with matching sel and demuxIn, during cycle N+1. Latency is one cycle.
- Back-to-back beats are supported: one word per cycle at full throughput, enable held high across consecutive cycles with sel advancing.
- Last beat accepted at edge N → DONE during cycle N+1 (done=1, enable=1, busy=1) → IDLE at N+2. A new start is sampled no earlier than edge N+2.
- in_ready is a combinational function of state and abort only. It never depends on in_valid.
- in_data must be stable only in the cycle it is accepted.

## Structure
- Shared package mac_pkg holds:
  - LANES=16, SEL_W=4, CNT_W=5
  - the state enumeration IDLE/RUN/DONE
  - the count-of-zero-means-LANES rule as a function
- One sub-module, mac_lane_counter: a 4-bit loadable wrap-around index counter with load (base) and inc ports.
- The FSM, remaining counter, output registers and lane_written mask stay in the top level.

## Test plan
- Reset then idle: assert reset mid-RUN after 3 beats → all outputs 0 in the same cycle; after release in_ready=0 until a new start.
- Basic burst: base=0, count=4, words 0x0011..0x0044 back-to-back → enable high for 4 consecutive cycles with sel 0,1,2,3 and the matching demuxIn; done one cycle after the last accepted beat; lane_written=0x000F.
- Wrap-around: base=14, count=4 → sel 14,15,0,1; lane_written=0xC003.
- Full burst, count=0: base=5 → 16 strobes, sel 5..15,0..4; lane_written=0xFFFF; exactly one done pulse.
- Gappy valid plus abort: base=2, count=8, in_valid toggling every other cycle, abort after 3 accepted beats → enable only on accepted beats (sel 2,3,4); no beat is accepted in the abort cycle; IDLE next cycle; no done; lane_written=0x001C.
- Start while busy: pulse start with base=9 during RUN → ignored; the burst completes on the original lanes.
